write_module: RTL and testbench

- Write-side producer for the dual-clock FIFO. It sits in the write clock domain and pushes a burst of incrementing 16-bit words into the FIFO's write port.
- It obeys the FIFO's wfull back-pressure, so no word is lost or duplicated.
- Optional inter-word pacing is set by parameter.
- It serves as the traffic source for read_module integration and as a reusable burst writer.

---
 rtl/write_module.sv | 100 ++++++++++
 tb/tb_write_module.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/write_module.sv
// Burst writer for the dual-clock FIFO write port: pushes incrementing words,
// honours wfull back-pressure and optionally paces words with idle gaps.
module write_module #(
    parameter int unsigned   DW        = 16,
    parameter int unsigned   LW        = 8,
    parameter logic [DW-1:0] DATA_INIT = 16'd10,
    parameter int unsigned   GAP       = 0
) (
    input  logic          wclk,
    input  logic          Wrst_n,
    input  logic          start,
    input  logic [LW-1:0] burst_len,
    input  logic          wfull,
    output logic [DW-1:0] wdata,
    output logic          winc,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] wcnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [LW-1:0] len;
    logic [31:0]   gap_cnt;
    logic          last_word;

    assign winc      = Wrst_n && (state == WRITE) && !wfull;
    assign last_word = (LW'(wcnt + 1'b1) == len);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (burst_len != '0) ? WRITE : DONE;
                end
            end
            WRITE: begin
                if (winc) begin
                    if (last_word) begin
                        state_next = DONE;
                    end else if (GAP > 0) begin
                        state_next = PAUSE;
                    end
                end
            end
            // Counter is checked before its decrement lands, so leaving at 2
            // places the next write exactly GAP cycles after the previous one.
            PAUSE: begin
                if (gap_cnt <= 32'd2) begin
                    state_next = WRITE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!Wrst_n) begin
            state   <= IDLE;
            wdata   <= DATA_INIT;
            wcnt    <= '0;
            len     <= '0;
            gap_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
            if (state == IDLE && start && burst_len != '0) begin
                len  <= burst_len;
                wcnt <= '0;
            end
            if (winc) begin
                wdata <= wdata + 1'b1;
                wcnt  <= wcnt + 1'b1;
                if (GAP > 0) begin
                    gap_cnt <= GAP;
                end
            end
            if (state == PAUSE) begin
                gap_cnt <= gap_cnt - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_write_module.sv
// Directed bench for write_module: three instances cover the default, GAP=2
// and wrapping DATA_INIT configurations; all share the same stimulus.
module tb_write_module;

    logic        wclk = 1'b0;
    logic        Wrst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  burst_len = '0;
    logic        wfull = 1'b0;

    logic [15:0] a_wdata, b_wdata, c_wdata;
    logic        a_winc, b_winc, c_winc;
    logic        a_busy, b_busy, c_busy;
    logic        a_done, b_done, c_done;
    logic [7:0]  a_wcnt, b_wcnt, c_wcnt;

    int total = 0;
    int bad = 0;

    always #5 wclk = ~wclk;

    write_module #(.DW(16), .LW(8), .DATA_INIT(16'd10), .GAP(0)) dut_a (
        .wclk(wclk), .Wrst_n(Wrst_n), .start(start), .burst_len(burst_len), .wfull(wfull),
        .wdata(a_wdata), .winc(a_winc), .busy(a_busy), .done(a_done), .wcnt(a_wcnt));

    write_module #(.DW(16), .LW(8), .DATA_INIT(16'd10), .GAP(2)) dut_b (
        .wclk(wclk), .Wrst_n(Wrst_n), .start(start), .burst_len(burst_len), .wfull(wfull),
        .wdata(b_wdata), .winc(b_winc), .busy(b_busy), .done(b_done), .wcnt(b_wcnt));

    write_module #(.DW(16), .LW(8), .DATA_INIT(16'hFFFE), .GAP(0)) dut_c (
        .wclk(wclk), .Wrst_n(Wrst_n), .start(start), .burst_len(burst_len), .wfull(wfull),
        .wdata(c_wdata), .winc(c_winc), .busy(c_busy), .done(c_done), .wcnt(c_wcnt));

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        Wrst_n = 1'b0; start = 1'b0; wfull = 1'b0; burst_len = '0;
        step(); step();
        Wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (a_wdata !== 16'd10) begin bad++; $display("FAIL reset_wdata got=%0d exp=10", a_wdata); end
        total++; if (c_wdata !== 16'hFFFE) begin bad++; $display("FAIL reset_wdata_c got=%h exp=fffe", c_wdata); end
        total++; if ({a_busy, a_done, a_winc, a_wcnt} !== 11'd0) begin bad++; $display("FAIL reset_flags got busy=%b done=%b winc=%b wcnt=%0d exp=all 0", a_busy, a_done, a_winc, a_wcnt); end
    endtask

    task automatic test_basic_burst();
        do_reset();
        start = 1'b1; burst_len = 8'd4;
        total++; if (a_winc !== 1'b0) begin bad++; $display("FAIL basic_idle_winc got=%b exp=0", a_winc); end
        step();
        start = 1'b0; burst_len = 8'd9;
        for (int i = 0; i < 4; i++) begin
            total++; if (a_winc !== 1'b1 || a_wdata !== 16'(10 + i)) begin bad++; $display("FAIL basic_word%0d got winc=%b wdata=%0d exp winc=1 wdata=%0d", i, a_winc, a_wdata, 10 + i); end
            total++; if (a_done !== 1'b0) begin bad++; $display("FAIL basic_early_done%0d got=%b exp=0", i, a_done); end
            step();
        end
        total++; if (a_done !== 1'b1 || a_busy !== 1'b1 || a_winc !== 1'b0 || a_wcnt !== 8'd4) begin bad++; $display("FAIL basic_done got done=%b busy=%b winc=%b wcnt=%0d exp 1 1 0 4", a_done, a_busy, a_winc, a_wcnt); end
        step();
        total++; if (a_done !== 1'b0 || a_busy !== 1'b0 || a_wdata !== 16'd14 || a_wcnt !== 8'd4) begin bad++; $display("FAIL basic_after got done=%b busy=%b wdata=%0d wcnt=%0d exp 0 0 14 4", a_done, a_busy, a_wdata, a_wcnt); end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_data [0:5];
        logic        exp_winc [0:5];
        logic        fulls    [0:5];
        exp_data = '{16'd10, 16'd11, 16'd11, 16'd11, 16'd12, 16'd0};
        exp_winc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        fulls    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        start = 1'b1; burst_len = 8'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wfull = fulls[i];
            #1;
            total++; if (a_winc !== exp_winc[i] || a_wdata !== exp_data[i]) begin bad++; $display("FAIL stall_cyc%0d got winc=%b wdata=%0d exp winc=%b wdata=%0d", i, a_winc, a_wdata, exp_winc[i], exp_data[i]); end
            step();
        end
        total++; if (a_done !== 1'b1 || a_wcnt !== 8'd3 || a_wdata !== 16'd13) begin bad++; $display("FAIL stall_done got done=%b wcnt=%0d wdata=%0d exp 1 3 13", a_done, a_wcnt, a_wdata); end
    endtask

    task automatic test_gap();
        logic exp_winc [0:5];
        logic exp_done [0:5];
        int   word;
        exp_winc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        start = 1'b1; burst_len = 8'd3;
        step();
        start = 1'b0;
        word = 10;
        for (int i = 0; i < 6; i++) begin
            total++; if (b_winc !== exp_winc[i] || b_done !== exp_done[i] || b_busy !== 1'b1) begin bad++; $display("FAIL gap_t%0d got winc=%b done=%b busy=%b exp winc=%b done=%b busy=1", i, b_winc, b_done, b_busy, exp_winc[i], exp_done[i]); end
            if (exp_winc[i]) begin
                total++; if (b_wdata !== 16'(word)) begin bad++; $display("FAIL gap_data_t%0d got=%0d exp=%0d", i, b_wdata, word); end
                word++;
            end
            step();
        end
        total++; if (b_busy !== 1'b0 || b_wcnt !== 8'd3) begin bad++; $display("FAIL gap_end got busy=%b wcnt=%0d exp 0 3", b_busy, b_wcnt); end
    endtask

    task automatic test_wrap_and_zero();
        logic [15:0] exp_data [0:2];
        exp_data = '{16'hFFFE, 16'hFFFF, 16'h0000};
        do_reset();
        start = 1'b1; burst_len = 8'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (c_winc !== 1'b1 || c_wdata !== exp_data[i]) begin bad++; $display("FAIL wrap_word%0d got winc=%b wdata=%h exp winc=1 wdata=%h", i, c_winc, c_wdata, exp_data[i]); end
            step();
        end
        total++; if (c_done !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b exp=1", c_done); end
        step();
        start = 1'b1; burst_len = 8'd0;
        step();
        start = 1'b0;
        total++; if (c_done !== 1'b1 || c_winc !== 1'b0 || c_busy !== 1'b1) begin bad++; $display("FAIL zero_done got done=%b winc=%b busy=%b exp 1 0 1", c_done, c_winc, c_busy); end
        step();
        total++; if (c_done !== 1'b0 || c_busy !== 1'b0 || c_wdata !== 16'h0001 || c_winc !== 1'b0) begin bad++; $display("FAIL zero_after got done=%b busy=%b wdata=%h winc=%b exp 0 0 0001 0", c_done, c_busy, c_wdata, c_winc); end
    endtask

    task automatic test_reset_mid_burst();
        int dones;
        int wincs;
        do_reset();
        start = 1'b1; burst_len = 8'd6;
        step();
        start = 1'b0;
        step(); step();
        total++; if (a_wdata !== 16'd12 || a_winc !== 1'b1) begin bad++; $display("FAIL midrst_pre got wdata=%0d winc=%b exp 12 1", a_wdata, a_winc); end
        Wrst_n = 1'b0;
        #1;
        total++; if (a_winc !== 1'b0) begin bad++; $display("FAIL midrst_winc got=%b exp=0", a_winc); end
        step();
        Wrst_n = 1'b1;
        total++; if (a_wdata !== 16'd10 || a_busy !== 1'b0 || a_wcnt !== 8'd0 || a_done !== 1'b0) begin bad++; $display("FAIL midrst_state got wdata=%0d busy=%b wcnt=%0d done=%b exp 10 0 0 0", a_wdata, a_busy, a_wcnt, a_done); end
        dones = 0; wincs = 0;
        for (int i = 0; i < 8; i++) begin
            dones += int'(a_done);
            wincs += int'(a_winc);
            step();
        end
        total++; if (dones != 0 || wincs != 0) begin bad++; $display("FAIL midrst_quiet got dones=%0d wincs=%0d exp 0 0", dones, wincs); end
    endtask

    task automatic test_back_to_back();
        int dones;
        int wincs;
        do_reset();
        start = 1'b1; burst_len = 8'd5;
        step();
        start = 1'b0;
        dones = 0; wincs = 0;
        for (int i = 0; i < 12; i++) begin
            start = (i == 2) || (i == 5);
            burst_len = 8'd2;
            #1;
            dones += int'(a_done);
            wincs += int'(a_winc);
            step();
        end
        start = 1'b0;
        total++; if (wincs != 5 || dones != 1) begin bad++; $display("FAIL ignore_start got wincs=%0d dones=%0d exp 5 1", wincs, dones); end
        total++; if (a_wdata !== 16'd15 || a_wcnt !== 8'd5 || a_busy !== 1'b0) begin bad++; $display("FAIL ignore_end got wdata=%0d wcnt=%0d busy=%b exp 15 5 0", a_wdata, a_wcnt, a_busy); end
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_basic_burst();
                test_backpressure();
                test_gap();
                test_wrap_and_zero();
                test_reset_mid_burst();
                test_back_to_back();
            end
            begin
                #100000;
                $display("FAIL timeout got=stuck exp=finished");
                $fatal(1, "timeout");
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
